// File: rtl/mod_updown_counter.sv
// Purpose: parametrised modulo-MODULUS up/down counter with clear, saturating load and cascade carry.
// Latency: Count and Err update one Clk edge after inputs are sampled; Carry and Zero are combinational.
// Backpressure: none; En (or an upstream Carry) is the only throttle, and the counter holds while it is low.
module mod_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Dir,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Carry,
  output logic             Zero,
  output logic             Err
);

  // Terminal count; with MODULUS == 2**WIDTH this is all-ones and nothing is out of range.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic             load_oor;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] nxt_up;
  logic [WIDTH-1:0] nxt_dn;
  logic [WIDTH-1:0] nxt_load;

  assign load_oor = (LoadVal > MAXV);
  assign at_max   = (Count == MAXV);
  assign at_zero  = (Count == '0);

  // Next-value candidates; any state above MAXV (only reachable through X/upset) steps to 0.
  always_comb begin
    nxt_up   = '0;
    nxt_dn   = '0;
    nxt_load = LoadVal;
    if (Count < MAXV) begin
      nxt_up = Count + WIDTH'(1);
    end
    if (at_zero) begin
      nxt_dn = MAXV;
    end else if (Count <= MAXV) begin
      nxt_dn = Count - WIDTH'(1);
    end
    if (load_oor) begin
      nxt_load = MAXV;
    end
  end

  // Count register: clear beats load beats count; reset is asynchronous.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Load) begin
      Count <= nxt_load;
    end else if (En) begin
      Count <= Dir ? nxt_up : nxt_dn;
    end
  end

  // Err flags an out-of-range load for exactly one cycle; a clear on the same edge masks it.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Err <= 1'b0;
    end else begin
      Err <= Load & ~Clr & load_oor;
    end
  end

  // Carry marks the cycle whose edge wraps the counter, so the next stage advances on that same edge.
  assign Carry = En & ~Clr & ~Load & ((Dir & at_max) | (~Dir & at_zero));
  assign Zero  = at_zero;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter (WIDTH=4, MODULUS=10) plus a two-digit cascade.
// Stimulus drives on the falling edge and queues what the outputs must show 2 ns later;
// a monitor pops each entry and compares it against the DUT outputs.
module tb_mod_updown_counter;

  logic       Clk;
  logic       Rst;
  logic       En, Dir, Clr, Load;
  logic [3:0] LoadVal;
  logic [3:0] Count;
  logic       Carry, Zero, Err;

  // Cascade: lo.Carry drives hi.En
  logic       c_en;
  logic [3:0] c_lo_cnt, c_hi_cnt;
  logic       c_lo_carry, c_hi_carry, c_lo_zero, c_hi_zero, c_lo_err, c_hi_err;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Dir(Dir), .Clr(Clr), .Load(Load),
    .LoadVal(LoadVal), .Count(Count), .Carry(Carry), .Zero(Zero), .Err(Err)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .Clk(Clk), .Rst(Rst), .En(c_en), .Dir(1'b1), .Clr(1'b0), .Load(1'b0),
    .LoadVal(4'd0), .Count(c_lo_cnt), .Carry(c_lo_carry), .Zero(c_lo_zero), .Err(c_lo_err)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .Clk(Clk), .Rst(Rst), .En(c_lo_carry), .Dir(1'b1), .Clr(1'b0), .Load(1'b0),
    .LoadVal(4'd0), .Count(c_hi_cnt), .Carry(c_hi_carry), .Zero(c_hi_zero), .Err(c_hi_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int    kind;   // 0 = main counter, 1 = cascade pair
    int    cnt;
    bit    carry;
    bit    zero;
    bit    err;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  bit   exp_err = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are settled 2 ns after the falling edge, well away from the rising edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge Clk);
      #2;
      while (sb.size() > 0) begin
        r = sb.pop_front();
        if (r.kind == 0) begin
          chk({r.tag, ".count"}, int'(Count), r.cnt);
          chk({r.tag, ".carry"}, int'(Carry), int'(r.carry));
          chk({r.tag, ".zero"},  int'(Zero),  int'(r.zero));
          chk({r.tag, ".err"},   int'(Err),   int'(r.err));
        end else begin
          chk({r.tag, ".value"}, int'(c_hi_cnt) * 10 + int'(c_lo_cnt), r.cnt);
          chk({r.tag, ".carry"}, int'(c_lo_carry), int'(r.carry));
        end
      end
    end
  end

  // One cycle of stimulus: queue what must be visible now, then record the post-edge expectation.
  task automatic step(input bit en, input bit dir, input bit clr, input bit ld,
                      input logic [3:0] lv, input bit exp_carry,
                      input int nxt, input bit nxt_err, input string tag);
    exp_t r;
    @(negedge Clk);
    En = en; Dir = dir; Clr = clr; Load = ld; LoadVal = lv;
    r.kind = 0; r.cnt = exp_cnt; r.carry = exp_carry; r.zero = (exp_cnt == 0);
    r.err = exp_err; r.tag = tag;
    sb.push_back(r);
    exp_cnt = nxt;
    exp_err = nxt_err;
  endtask

  // Reset pulse between edges with En=1, Dir=0: Count must drop to 0 at once and Carry rises.
  task automatic rst_pulse_down();
    exp_t r;
    @(negedge Clk);
    En = 1'b1; Dir = 1'b0; Clr = 1'b0; Load = 1'b0; LoadVal = 4'd0;
    Rst = 1'b0;
    r.kind = 0; r.cnt = 0; r.carry = 1'b1; r.zero = 1'b1; r.err = 1'b0; r.tag = "rst_mid";
    sb.push_back(r);
    #4;
    Rst = 1'b1;
    exp_cnt = 9;   // released before the edge, which decrements 0 -> 9
    exp_err = 1'b0;
  endtask

  initial begin
    exp_t r;
    Rst = 1'b0; En = 1'b0; Dir = 1'b1; Clr = 1'b0; Load = 1'b0; LoadVal = 4'd0;
    c_en = 1'b0;

    // Reset state while Rst is held low
    @(negedge Clk);
    r.kind = 0; r.cnt = 0; r.carry = 1'b0; r.zero = 1'b1; r.err = 1'b0; r.tag = "reset";
    sb.push_back(r);
    @(negedge Clk);            // t=20 ns
    Rst = 1'b1;

    // Hold with En=0
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 4'd0, 0, 0, 0, "hold");

    // Up wrap: 0..9 then 0, Carry only at 9
    for (int i = 0; i <= 10; i++)
      step(1, 1, 0, 0, 4'd0, (i % 10) == 9, (i + 1) % 10, 0, "up");

    // Down wrap: load 2, then 2,1,0,9,8 with Carry only at 0
    step(1, 0, 0, 1, 4'd2, 0, 2, 0, "ld2");
    step(1, 0, 0, 0, 4'd0, 0, 1, 0, "dn2");
    step(1, 0, 0, 0, 4'd0, 0, 0, 0, "dn1");
    step(1, 0, 0, 0, 4'd0, 1, 9, 0, "dn0");
    step(1, 0, 0, 0, 4'd0, 0, 8, 0, "dn9");
    step(0, 0, 0, 0, 4'd0, 0, 8, 0, "dn8");

    // Load range and Err pulse
    step(0, 1, 0, 1, 4'd7,  0, 7, 0, "ld7");
    step(0, 1, 0, 1, 4'd12, 0, 9, 1, "ld12");
    step(0, 1, 0, 0, 4'd0,  0, 9, 0, "err_hi");
    step(0, 1, 0, 0, 4'd0,  0, 9, 0, "err_lo");

    // Priority: clear beats load and count
    step(0, 1, 0, 1, 4'd5,  0, 5, 0, "ld5");
    step(1, 1, 1, 1, 4'd3,  0, 0, 0, "clr_wins");
    step(1, 1, 1, 1, 4'd12, 0, 0, 0, "clr_bad_ld");
    step(0, 1, 0, 0, 4'd0,  0, 0, 0, "clr_no_err");

    // Priority: load beats count and suppresses Carry at 9
    step(0, 1, 0, 1, 4'd9,  0, 9, 0, "ld9");
    step(1, 1, 0, 1, 4'd4,  0, 4, 0, "ld_wins");
    step(0, 1, 0, 0, 4'd0,  0, 4, 0, "ld_wins_hold");

    // Asynchronous reset mid-count from 6
    step(0, 1, 0, 1, 4'd6,  0, 6, 0, "ld6");
    step(0, 1, 0, 0, 4'd0,  0, 6, 0, "at6");
    rst_pulse_down();
    step(0, 1, 0, 0, 4'd0,  0, 9, 0, "post_rst");
    step(0, 1, 0, 0, 4'd0,  0, 9, 0, "post_rst2");

    // Cascade: 00..99 then 00; the high digit moves on the edge where the low digit wraps
    for (int i = 0; i <= 100; i++) begin
      @(negedge Clk);
      c_en = 1'b1;
      r.kind = 1; r.cnt = i % 100; r.carry = ((i % 10) == 9);
      r.zero = 1'b0; r.err = 1'b0; r.tag = "cascade";
      sb.push_back(r);
    end
    @(negedge Clk);
    c_en = 1'b0;
    r.kind = 1; r.cnt = 1; r.carry = 1'b0; r.zero = 1'b0; r.err = 1'b0; r.tag = "cascade_end";
    sb.push_back(r);

    @(negedge Clk);
    @(negedge Clk);
    #4;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
